muldiv_unit: RTL

- Iterative RV32M multiply/divide unit; sits beside the combinational ALU in the execute stage.
- The ALU gives single-cycle results. This unit takes an M-extension op and operands, then returns the result over a start/busy/done handshake.
- The core stalls while o_busy is high and writes o_1 to the register file on o_done.
- Radix-2 implementation: shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
//==== muldiv_pkg -- shared encodings and constants for the RV32M unit (rev 1.0) ====
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
//==== muldiv_step -- one radix-2 iteration: shift-add multiply or restoring divide (rev 1.0) ====
`default_nettype none

module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_hi;
  logic [XLEN:0]   w_rsh;
  logic [XLEN:0]   w_diff;
  logic            w_nob;
  logic [XLEN-1:0] w_rem;

  // Multiply: high half accumulates, low half holds the multiplier being consumed
  assign w_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
  assign w_hi  = acc_i[0] ? w_sum : {1'b0, acc_i[2*XLEN-1:XLEN]};

  // Divide: high half is the partial remainder, low half shifts the dividend out
  assign w_rsh  = acc_i[2*XLEN-1:XLEN-1];
  assign w_diff = w_rsh - {1'b0, opnd_i};
  assign w_nob  = ~w_diff[XLEN];
  assign w_rem  = w_nob ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];

  always_comb begin
    acc_o  = {w_hi, acc_i[XLEN-1:1]};
    qbit_o = 1'b0;
    if (mode_i) begin
      acc_o  = {w_rem, acc_i[XLEN-2:0], 1'b0};
      qbit_o = w_nob;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//==== muldiv_unit -- iterative RV32M multiply/divide with start/busy/done handshake (rev 1.0) ====
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_1,
  input  logic [XLEN-1:0] i_2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_1
);

  import muldiv_pkg::*;

  localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              w_sgn1, w_sgn2, w_s1, w_s2;
  logic [XLEN-1:0]   w_abs1, w_abs2;
  logic              w_div0, w_ovf;
  logic [XLEN-1:0]   w_spec_res;
  logic [2*XLEN-1:0] w_step_acc, w_acc_nx, w_prod;
  logic              w_qbit;
  logic [XLEN-1:0]   w_dv, w_final;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_i (is_div_op(op_q)),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (w_step_acc),
    .qbit_o (w_qbit)
  );

  assign w_acc_nx = {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_qbit};

  // Operand conditioning at the accept edge
  assign w_sgn1 = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_sgn2 = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_s1   = w_sgn1 & i_1[XLEN-1];
  assign w_s2   = w_sgn2 & i_2[XLEN-1];
  assign w_abs1 = w_s1 ? -i_1 : i_1;
  assign w_abs2 = w_s2 ? -i_2 : i_2;

  assign w_div0 = is_div_op(i_op) && (i_2 == '0);
  assign w_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                  (i_1 == XLEN'(OVF_Q)) && (i_2 == {XLEN{1'b1}});

  // op[1] selects the remainder within the divide family
  always_comb begin
    w_spec_res = i_op[1] ? {XLEN{1'b0}} : XLEN'(OVF_Q);
    if (w_div0) w_spec_res = i_op[1] ? i_1 : XLEN'(DIV0_Q);
  end

  // Sign fix-up of the final iteration's result
  assign w_prod = neg_q ? -w_acc_nx : w_acc_nx;
  assign w_dv   = op_q[1] ? w_acc_nx[2*XLEN-1:XLEN] : w_acc_nx[XLEN-1:0];

  always_comb begin
    w_final = (op_q == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    if (is_div_op(op_q)) w_final = neg_q ? -w_dv : w_dv;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    case (state_q)
      CALC: begin
        acc_d = w_acc_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          res_d   = w_final;
        end
      end
      default: begin
        state_d = IDLE;
        if (i_start) begin
          op_d  = i_op;
          cnt_d = '0;
          if (is_div_op(i_op)) begin
            neg_d  = i_op[1] ? w_s1 : (w_s1 ^ w_s2);
            acc_d  = {{XLEN{1'b0}}, w_abs1};
            opnd_d = w_abs2;
          end else begin
            neg_d  = w_s1 ^ w_s2;
            acc_d  = {{XLEN{1'b0}}, w_abs2};
            opnd_d = w_abs1;
          end
          if (w_div0 || w_ovf) begin
            state_d = DONE;
            res_d   = w_spec_res;
          end else begin
            state_d = CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  assign o_busy = (state_q == CALC);
  assign o_done = (state_q == DONE);
  assign o_1    = res_q;

endmodule

`default_nettype wire
